// File: rtl/vigna_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vigna_pkg
//  Description : Shared constants for the vigna fetch path. Defines the
//                address width, the instruction size, and the layout of a
//                prefetch-queue entry, packed as {addr, data, fault} from MSB
//                to LSB.
//  Revision    : 1.0 - initial release
// ============================================================================
package vigna_pkg;

    localparam int VIGNA_ADDR_W        = 32;
    localparam int VIGNA_INST_BYTES    = 4;

    // Queue-entry layout. The fault flag is the LSB, the instruction word
    // sits above it, and the fetch address occupies the top bits.
    localparam int VIGNA_ENT_FAULT_W   = 1;
    localparam int VIGNA_ENT_FAULT_OFS = 0;
    localparam int VIGNA_ENT_DATA_OFS  = VIGNA_ENT_FAULT_OFS + VIGNA_ENT_FAULT_W;

    function automatic int vigna_ent_addr_ofs(input int data_w);
        return VIGNA_ENT_DATA_OFS + data_w;
    endfunction

    function automatic int vigna_ent_w(input int data_w);
        return vigna_ent_addr_ofs(data_w) + VIGNA_ADDR_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vigna_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vigna_fifo
//  Description : Synchronous DEPTH x WIDTH FIFO with flush, wrap-around
//                pointers and an occupancy count. DEPTH must be a power of
//                two so that the pointers wrap naturally.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, resetn  : clock and asynchronous active-low reset
//    i_flush      : empty the FIFO; overrides push and pop in the same cycle
//    i_push       : write i_push_data; allowed when full only with a pop
//    i_pop        : drop the head entry; ignored when empty
//    o_count      : occupancy, 0..DEPTH
//    o_head       : head entry; undefined when o_count == 0
// ============================================================================
module vigna_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [WIDTH-1:0]           o_head
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_pop  = i_pop & (r_count != '0) & ~i_flush;
    // A push into a full FIFO is accepted only when a pop frees the slot.
    assign w_push = i_push & ~i_flush & ((r_count != c_cnt_w'(DEPTH)) | w_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/vigna_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vigna_fetch_unit
//  Description : Instruction prefetcher. Issues one outstanding request at a
//                time on the instruction bus, queues returned words in a
//                DEPTH-entry FIFO, and supports flushing redirects.
//                Build option: VIGNA_FETCH_ALIGN_CHECK_EN. When it is
//                defined, a misaligned redirect queues a single fault entry
//                and halts fetch until the next redirect.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, resetn                          : clock, async active-low reset
//    i_valid/i_ready/i_addr/i_rdata       : instruction bus request/response
//    inst_valid/inst_ready/inst_data/
//    inst_addr/inst_fault                 : head of the prefetch queue
//    redir_valid/redir_addr               : single-cycle fetch redirect
// ============================================================================
module vigna_fetch_unit
    import vigna_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4,
    parameter int          DATA_W     = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    i_valid,
    input  logic                    i_ready,
    output logic [VIGNA_ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0]       i_rdata,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [DATA_W-1:0]       inst_data,
    output logic [VIGNA_ADDR_W-1:0] inst_addr,
    input  logic                    redir_valid,
    input  logic [VIGNA_ADDR_W-1:0] redir_addr,
    output logic                    inst_fault
);

    localparam int c_ent_w    = vigna_ent_w(DATA_W);
    localparam int c_addr_ofs = vigna_ent_addr_ofs(DATA_W);
    localparam int c_cnt_w    = $clog2(DEPTH + 1);

    logic [VIGNA_ADDR_W-1:0] r_pc;
    logic [VIGNA_ADDR_W-1:0] r_req_addr;
    logic                    r_req_valid;
    logic                    r_drop;

    logic                    w_hs;
    logic                    w_busy_next;
    logic                    w_deq;
    logic                    w_word_enq;
    logic                    w_enq;
    logic                    w_issue;
    logic                    w_halted_next;
    logic [VIGNA_ADDR_W-1:0] w_redir_pc;
    logic [VIGNA_ADDR_W-1:0] w_pc_base;
    logic [c_ent_w-1:0]      w_enq_ent;
    logic [c_ent_w-1:0]      w_head_ent;
    logic [c_cnt_w-1:0]      w_count;
    logic [c_cnt_w-1:0]      w_count_next;

    assign w_hs        = r_req_valid & i_ready;
    assign w_busy_next = r_req_valid & ~i_ready;
    assign w_deq       = inst_valid & inst_ready;
    // A redirect flushes the queue, so a word landing in the same cycle is
    // discarded just like one flagged by the drop bit.
    assign w_word_enq  = w_hs & ~r_drop & ~redir_valid;

`ifdef VIGNA_FETCH_ALIGN_CHECK_EN
    logic                    r_halted;
    logic                    r_fault_pend;
    logic [VIGNA_ADDR_W-1:0] r_fault_addr;
    logic                    w_misaligned;
    logic                    w_fault_enq;

    assign w_misaligned  = redir_valid & (redir_addr[1:0] != 2'b00);
    assign w_redir_pc    = redir_addr;
    // The fault entry waits until the bus is idle so that it lands after
    // any in-flight (dropped) word and never competes with it for a slot.
    assign w_fault_enq   = r_fault_pend & ~r_req_valid & ~redir_valid;
    assign w_halted_next = redir_valid ? w_misaligned : r_halted;
    assign w_enq         = w_word_enq | w_fault_enq;
    assign w_enq_ent     = w_fault_enq ? {r_fault_addr, {DATA_W{1'b0}}, 1'b1}
                                       : {r_req_addr, i_rdata, 1'b0};
    assign inst_fault    = inst_valid & w_head_ent[VIGNA_ENT_FAULT_OFS];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_halted     <= 1'b0;
            r_fault_pend <= 1'b0;
            r_fault_addr <= RESET_ADDR;
        end else if (redir_valid) begin
            r_halted     <= w_misaligned;
            r_fault_pend <= w_misaligned;
            r_fault_addr <= redir_addr;
        end else if (w_fault_enq) begin
            r_fault_pend <= 1'b0;
        end
    end
`else
    logic w_unused;

    assign w_redir_pc    = {redir_addr[VIGNA_ADDR_W-1:2], 2'b00};
    assign w_halted_next = 1'b0;
    assign w_enq         = w_word_enq;
    assign w_enq_ent     = {r_req_addr, i_rdata, 1'b0};
    assign inst_fault    = 1'b0;
    assign w_unused      = &{1'b0, redir_addr[1:0], w_head_ent[VIGNA_ENT_FAULT_OFS]};
`endif

    // Occupancy after this edge; issue decisions use it so that a slot is
    // always reserved for the request being launched.
    always_comb begin
        w_count_next = w_count;
        if (redir_valid) begin
            w_count_next = '0;
        end else if (w_enq && !w_deq) begin
            w_count_next = w_count + c_cnt_w'(1);
        end else if (!w_enq && w_deq) begin
            w_count_next = w_count - c_cnt_w'(1);
        end
    end

    assign w_pc_base = redir_valid ? w_redir_pc : r_pc;
    assign w_issue   = ~w_busy_next & (w_count_next < c_cnt_w'(DEPTH)) & ~w_halted_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc        <= RESET_ADDR;
            r_req_addr  <= RESET_ADDR;
            r_req_valid <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req_valid <= 1'b1;
                r_req_addr  <= w_pc_base;
                r_pc        <= w_pc_base + VIGNA_ADDR_W'(VIGNA_INST_BYTES);
            end else begin
                r_req_valid <= w_busy_next;
                r_pc        <= w_pc_base;
            end
            // Only a request still waiting after this edge needs marking;
            // one completing now is already discarded by the flush.
            if (redir_valid) begin
                r_drop <= w_busy_next;
            end else if (w_hs) begin
                r_drop <= 1'b0;
            end
        end
    end

    vigna_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ent_w)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_flush     (redir_valid),
        .i_push      (w_enq),
        .i_push_data (w_enq_ent),
        .i_pop       (w_deq),
        .o_count     (w_count),
        .o_head      (w_head_ent)
    );

    assign i_valid    = r_req_valid;
    assign i_addr     = r_req_addr;
    assign inst_valid = (w_count != '0);
    assign inst_data  = w_head_ent[VIGNA_ENT_DATA_OFS +: DATA_W];
    assign inst_addr  = w_head_ent[c_addr_ofs +: VIGNA_ADDR_W];

endmodule
`default_nettype wire

// File: tb/tb_vigna_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vigna_fetch_unit
//  Description : Directed self-checking bench for vigna_fetch_unit. The
//                instruction memory model returns ~addr as the data word.
//                Build option VIGNA_FETCH_ALIGN_CHECK_EN selects the
//                misaligned-redirect scenario that matches the RTL build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vigna_fetch_unit;

    logic        clk         = 1'b0;
    logic        resetn      = 1'b0;
    logic        i_valid;
    logic        i_ready     = 1'b0;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        inst_valid;
    logic        inst_ready  = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_addr;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_addr  = 32'h0;
    logic        inst_fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign i_rdata = ~i_addr;

    vigna_fetch_unit #(
        .RESET_ADDR (32'h0000_0000),
        .DEPTH      (4),
        .DATA_W     (32)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_addr   (inst_addr),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .inst_fault  (inst_fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves resetn released just after an edge; the next edge is "E1".
    task automatic do_reset();
        step();
        resetn      = 1'b0;
        i_ready     = 1'b0;
        inst_ready  = 1'b0;
        redir_valid = 1'b0;
        redir_addr  = 32'h0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        step();
        resetn = 1'b0;
        #1;
        n_checks++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL reset_i_valid: got %b want 0", i_valid); end
        n_checks++; if (i_addr !== 32'h0) begin n_fail++; $display("FAIL reset_i_addr: got %h want 00000000", i_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        n_checks++; if (inst_fault !== 1'b0) begin n_fail++; $display("FAIL reset_inst_fault: got %b want 0", inst_fault); end
        step();
        resetn = 1'b1;
        #1;
        n_checks++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_early: got %b want 0", i_valid); end
        step();
        n_checks++; if (i_valid !== 1'b1) begin n_fail++; $display("FAIL reset_first_valid: got %b want 1", i_valid); end
        n_checks++; if (i_addr !== 32'h0) begin n_fail++; $display("FAIL reset_first_addr: got %h want 00000000", i_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_a;
        do_reset();
        i_ready    = 1'b1;
        inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            exp_a = 32'(4 * k);
            n_checks++; if (i_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, i_valid); end
            n_checks++; if (i_addr !== exp_a) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h want %h", k, i_addr, exp_a); end
            if (k == 0) begin
                n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_inst_valid0: got %b want 0", inst_valid); end
            end else begin
                exp_a = 32'(4 * (k - 1));
                n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_inst_valid[%0d]: got %b want 1", k, inst_valid); end
                n_checks++; if (inst_addr !== exp_a) begin n_fail++; $display("FAIL stream_inst_addr[%0d]: got %h want %h", k, inst_addr, exp_a); end
                n_checks++; if (inst_data !== ~exp_a) begin n_fail++; $display("FAIL stream_inst_data[%0d]: got %h want %h", k, inst_data, ~exp_a); end
            end
        end
    endtask

    task automatic test_backpressure();
        int          hs;
        logic [31:0] exp_a;
        do_reset();
        i_ready    = 1'b1;
        inst_ready = 1'b0;
        hs = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (i_valid === 1'b1) hs++;
        end
        n_checks++; if (hs != 4) begin n_fail++; $display("FAIL bp_handshakes: got %0d want 4", hs); end
        n_checks++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL bp_full_idle: got %b want 0", i_valid); end
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL bp_head: got %h want 00000000", inst_addr); end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n_checks++; if (i_valid !== 1'b1) begin n_fail++; $display("FAIL bp_refill_valid: got %b want 1", i_valid); end
        n_checks++; if (i_addr !== 32'h10) begin n_fail++; $display("FAIL bp_refill_addr: got %h want 00000010", i_addr); end
        hs = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (i_valid === 1'b1) hs++;
        end
        n_checks++; if (hs != 1) begin n_fail++; $display("FAIL bp_one_refill: got %0d want 1", hs); end
        i_ready    = 1'b0;
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_a = 32'(4 + 4 * k);
            n_checks++; if (inst_addr !== exp_a) begin n_fail++; $display("FAIL bp_drain[%0d]: got %h want %h", k, inst_addr, exp_a); end
            step();
        end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", inst_valid); end
        n_checks++; if (i_addr !== 32'h14) begin n_fail++; $display("FAIL bp_next_addr: got %h want 00000014", i_addr); end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        i_ready    = 1'b1;
        inst_ready = 1'b0;
        step();
        step();
        i_ready = 1'b0;
        step();
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL rp_pre_valid: got %b want 1", inst_valid); end
        redir_valid = 1'b1;
        redir_addr  = 32'h100;
        step();
        redir_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rp_flush: got %b want 0", inst_valid); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (i_addr !== 32'h4 || i_valid !== 1'b1) begin n_fail++; $display("FAIL rp_hold[%0d]: got %b/%h want 1/00000004", k, i_valid, i_addr); end
            if (k < 2) step();
        end
        i_ready    = 1'b1;
        inst_ready = 1'b1;
        step();
        n_checks++; if (i_addr !== 32'h100) begin n_fail++; $display("FAIL rp_new_addr: got %h want 00000100", i_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rp_dropped: got %b want 0", inst_valid); end
        step();
        n_checks++; if (inst_addr !== 32'h100 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL rp_head: got %b/%h want 1/00000100", inst_valid, inst_addr); end
        n_checks++; if (inst_data !== ~32'h100) begin n_fail++; $display("FAIL rp_data: got %h want %h", inst_data, ~32'h100); end
        n_checks++; if (i_addr !== 32'h104) begin n_fail++; $display("FAIL rp_next: got %h want 00000104", i_addr); end
    endtask

    task automatic test_redirect_handshake();
        do_reset();
        i_ready    = 1'b1;
        inst_ready = 1'b0;
        repeat (5) step();
        n_checks++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL rh_full_idle: got %b want 0", i_valid); end
        inst_ready = 1'b1;
        step();
        n_checks++; if (i_addr !== 32'h10 || i_valid !== 1'b1) begin n_fail++; $display("FAIL rh_pending: got %b/%h want 1/00000010", i_valid, i_addr); end
        redir_valid = 1'b1;
        redir_addr  = 32'h100;
        step();
        redir_valid = 1'b0;
        i_ready     = 1'b0;
        inst_ready  = 1'b0;
        n_checks++; if (i_addr !== 32'h100 || i_valid !== 1'b1) begin n_fail++; $display("FAIL rh_next_req: got %b/%h want 1/00000100", i_valid, i_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rh_flushed: got %b want 0", inst_valid); end
        step();
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rh_no_enq: got %b want 0", inst_valid); end
        i_ready = 1'b1;
        step();
        n_checks++; if (inst_addr !== 32'h100 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL rh_head: got %b/%h want 1/00000100", inst_valid, inst_addr); end
    endtask

    task automatic test_redirect_idle();
        do_reset();
        i_ready    = 1'b1;
        inst_ready = 1'b0;
        repeat (5) step();
        redir_valid = 1'b1;
        redir_addr  = 32'h200;
        step();
        redir_valid = 1'b0;
        n_checks++; if (i_addr !== 32'h200 || i_valid !== 1'b1) begin n_fail++; $display("FAIL ri_issue: got %b/%h want 1/00000200", i_valid, i_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL ri_flush: got %b want 0", inst_valid); end
        step();
        n_checks++; if (inst_addr !== 32'h200 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL ri_head: got %b/%h want 1/00000200", inst_valid, inst_addr); end
        n_checks++; if (i_addr !== 32'h204) begin n_fail++; $display("FAIL ri_next: got %h want 00000204", i_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        i_ready    = 1'b0;
        inst_ready = 1'b1;
        step();
        redir_valid = 1'b1;
        redir_addr  = 32'hFFFF_FFFC;
        step();
        redir_valid = 1'b0;
        i_ready     = 1'b1;
        step();
        n_checks++; if (i_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h want fffffffc", i_addr); end
        step();
        n_checks++; if (i_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h want 00000000", i_addr); end
        n_checks++; if (inst_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_head: got %h want fffffffc", inst_addr); end
        step();
        n_checks++; if (i_addr !== 32'h4 || inst_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_after: got %h/%h want 00000004/00000000", i_addr, inst_addr); end
    endtask

`ifdef VIGNA_FETCH_ALIGN_CHECK_EN
    task automatic test_misaligned();
        do_reset();
        i_ready    = 1'b0;
        inst_ready = 1'b0;
        step();
        redir_valid = 1'b1;
        redir_addr  = 32'h102;
        step();
        redir_valid = 1'b0;
        i_ready     = 1'b1;
        step();
        n_checks++; if (i_valid !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL mis_drop: got %b/%b want 0/0", i_valid, inst_valid); end
        step();
        n_checks++; if (inst_valid !== 1'b1 || inst_fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b/%b want 1/1", inst_valid, inst_fault); end
        n_checks++; if (inst_addr !== 32'h102) begin n_fail++; $display("FAIL mis_addr: got %h want 00000102", inst_addr); end
        n_checks++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL mis_data: got %h want 00000000", inst_data); end
        repeat (3) step();
        n_checks++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL mis_halted: got %b want 0", i_valid); end
        redir_valid = 1'b1;
        redir_addr  = 32'h200;
        inst_ready  = 1'b1;
        step();
        redir_valid = 1'b0;
        n_checks++; if (i_valid !== 1'b1 || i_addr !== 32'h200) begin n_fail++; $display("FAIL mis_resume: got %b/%h want 1/00000200", i_valid, i_addr); end
        n_checks++; if (inst_valid !== 1'b0 || inst_fault !== 1'b0) begin n_fail++; $display("FAIL mis_cleared: got %b/%b want 0/0", inst_valid, inst_fault); end
    endtask
`else
    task automatic test_misaligned();
        do_reset();
        i_ready    = 1'b0;
        inst_ready = 1'b1;
        step();
        redir_valid = 1'b1;
        redir_addr  = 32'h302;
        step();
        redir_valid = 1'b0;
        i_ready     = 1'b1;
        step();
        n_checks++; if (i_addr !== 32'h300) begin n_fail++; $display("FAIL mis_ignored: got %h want 00000300", i_addr); end
        step();
        n_checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h300) begin n_fail++; $display("FAIL mis_head: got %b/%h want 1/00000300", inst_valid, inst_addr); end
        n_checks++; if (inst_fault !== 1'b0) begin n_fail++; $display("FAIL mis_fault_tied: got %b want 0", inst_fault); end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        i_ready = 1'b0;
        redir_valid = 1'b1;
        redir_addr  = 32'h80;
        step();
        redir_valid = 1'b0;
        n_checks++; if (i_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pending: got %b want 1", i_valid); end
        resetn = 1'b0;
        #1;
        n_checks++; if (i_valid !== 1'b0 || i_addr !== 32'h0) begin n_fail++; $display("FAIL rm_async: got %b/%h want 0/00000000", i_valid, i_addr); end
        step();
        resetn  = 1'b1;
        i_ready = 1'b1;
        step();
        n_checks++; if (i_valid !== 1'b1 || i_addr !== 32'h0) begin n_fail++; $display("FAIL rm_restart: got %b/%h want 1/00000000", i_valid, i_addr); end
        step();
        n_checks++; if (i_addr !== 32'h4 || inst_addr !== 32'h0) begin n_fail++; $display("FAIL rm_no_drop: got %h/%h want 00000004/00000000", i_addr, inst_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_pending();
        test_redirect_handshake();
        test_redirect_idle();
        test_wrap();
        test_misaligned();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vigna_fetch_unit.md
VIGNA_FETCH_UNIT -- requirements
Module: vigna_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries; power of two, at least 2.
REQ-003 SHALL have parameter DATA_W, default 32, meaning instruction word width; address width fixed at 32.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have ports i_valid (output, 1), i_ready (input, 1), i_addr (output, 32) and i_rdata (input, DATA_W): instruction bus; transfer completes in a cycle with i_valid && i_ready, and i_rdata is valid in that cycle.
REQ-007 SHALL have ports inst_valid (output, 1), inst_ready (input, 1), inst_data (output, DATA_W) and inst_addr (output, 32): consumer side; an entry is dequeued when inst_valid && inst_ready.
REQ-008 SHALL have ports redir_valid (input, 1) and redir_addr (input, 32): a one-cycle pulse that redirects fetch.
REQ-009 SHALL have port inst_fault, output, 1 bit: marks the head entry as a misaligned-redirect fault.

Function
REQ-010 SHALL keep a fetch PC (next address to request), a request-address register driving i_addr, a queue occupancy count 0..DEPTH, and a drop flag.
REQ-011 SHALL raise i_valid (registered) when i_valid is low, count < DEPTH and not halted; i_addr = PC; PC advances by 4 at issue.
REQ-012 SHALL hold i_valid and i_addr stable until i_ready; they SHALL NOT be withdrawn or changed mid-request, including on redirect.
REQ-013 On handshake SHALL enqueue {i_addr, i_rdata, fault=0} unless the drop flag is set, then clear the drop flag.
REQ-014 SHALL keep i_valid high on the cycle after a handshake (back-to-back) when post-update count < DEPTH; sustained throughput 1 word/cycle.
REQ-015 Issue rule SHALL guarantee a free slot for every outstanding request; enqueue into a full queue is impossible by construction.
REQ-016 inst_valid SHALL equal count != 0; head data/addr/fault are registered; an enqueued word is visible the cycle after its handshake (latency 1).
REQ-017 Simultaneous enqueue and dequeue SHALL leave count unchanged; dequeue from full with enqueue is legal.
REQ-018 Redirect SHALL flush the queue (count=0, inst_valid low next cycle), set PC=redir_addr, and have priority over a same-cycle dequeue and enqueue.
REQ-019 Redirect with a request pending (i_valid high) SHALL set the drop flag, including the handshake cycle itself; the first request to redir_addr issues the cycle after the dropped handshake.
REQ-020 Redirect with no request pending SHALL issue to redir_addr in the next cycle.
REQ-021 PC SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Reset
REQ-022 While resetn is low: i_valid=0, i_addr=RESET_ADDR, PC=RESET_ADDR, count=0, inst_valid=0, inst_fault=0, drop=0, halted=0.
REQ-023 The first i_valid SHALL rise on the first clock edge after resetn deasserts; reset mid-request SHALL drop i_valid immediately and discard all state.

Configuration
REQ-024 With macro VIGNA_FETCH_ALIGN_CHECK_EN defined, a redirect with redir_addr[1:0] != 0 SHALL enqueue one entry {redir_addr, 0, fault=1} once no request is pending.
REQ-025 Under VIGNA_FETCH_ALIGN_CHECK_EN, that fault SHALL set halted, blocking issue until the next redirect.
REQ-026 Without VIGNA_FETCH_ALIGN_CHECK_EN, redir_addr[1:0] SHALL be ignored (treated as 0) and inst_fault SHALL be tied 0.

Structure
REQ-027 Shared package vigna_pkg SHALL hold VIGNA_ADDR_W=32, VIGNA_INST_BYTES=4 and the queue-entry field widths/offsets.
REQ-028 Queue storage SHALL be sub-module vigna_fifo, a synchronous DEPTH x (32+DATA_W+1) FIFO with flush, wrap-around pointers and an occupancy count.

Verification
REQ-029 Reset release, i_ready=1, inst_ready=1 -> i_addr 0x0, 0x4, 0x8 on consecutive cycles; inst_valid from cycle 2 with matching inst_addr.
REQ-030 inst_ready=0, DEPTH=4 -> exactly 4 handshakes, then i_valid stays low; one dequeue -> exactly one new request.
REQ-031 Redirect to 0x100 while i_valid=1, i_ready=0 for 3 cycles -> i_addr unchanged until ready; that word dropped; next i_addr=0x100; queue empty after redirect.
REQ-032 Redirect coincident with handshake and dequeue on a full queue -> no enqueue, count=0, next request 0x100.
REQ-033 PC=0xFFFF_FFFC -> next request 0x0000_0000.
REQ-034 With VIGNA_FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> one entry inst_fault=1, inst_addr=0x102, no bus request until redirect to 0x200.
